// File: rtl/wide_add_pkg.sv
// Shared types for the chunked wide adder: controller state encoding and
// the chunk-index width helper.
package wide_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bits needed to count 0..chunks-1; never less than one bit.
  function automatic int idx_width(input int chunks);
    return (chunks > 1) ? $clog2(chunks) : 1;
  endfunction

endpackage

// File: rtl/carry_lookahead_adder.sv
// WIDTH-bit adder; every carry is a flat function of generate/propagate
// terms and the incoming carry.
module carry_lookahead_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] prop;

  assign gen  = a & b;
  assign prop = a ^ b;

  always_comb begin
    logic c_i;
    sum  = '0;
    cout = 1'b0;
    c_i  = 1'b0;
    for (int i = 0; i <= WIDTH; i++) begin
      c_i = cin;
      for (int j = 0; j < i; j++) begin
        c_i = gen[j] | (prop[j] & c_i);
      end
      if (i < WIDTH) begin
        sum[i] = prop[i] ^ c_i;
      end else begin
        cout = c_i;
      end
    end
  end

endmodule

// File: rtl/wide_add_sequencer.sv
// Adds two CHUNKS*WIDTH-bit operands one chunk per clock, LSB first, on one
// shared carry_lookahead_adder. WIDE_ADD_SEQUENCER_SUB_EN adds a subtract mode.
//
// state | meaning
// IDLE  | waiting for start; operands captured when start is seen
// ADD   | one chunk summed per clock, carry chained through carry_q
// DONE  | one-cycle done pulse, z/carry_out hold the finished result
module wide_add_sequencer
  import wide_add_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int CHUNKS = 4,
  localparam int N     = WIDTH * CHUNKS
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         carry_in,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
`ifdef WIDE_ADD_SEQUENCER_SUB_EN
  input  logic         sub,
`endif
  output logic         busy,
  output logic         done,
  output logic [N-1:0] z,
  output logic         carry_out
);

  localparam int IDX_W = idx_width(CHUNKS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

  state_e state_q, state_d;

  logic [CHUNKS-1:0][WIDTH-1:0] x_q, x_d;
  logic [CHUNKS-1:0][WIDTH-1:0] y_q, y_d;
  logic [CHUNKS-1:0][WIDTH-1:0] z_q, z_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic                         carry_q, carry_d;
  logic                         cout_q, cout_d;
`ifdef WIDE_ADD_SEQUENCER_SUB_EN
  logic                         sub_q, sub_d;
`endif

  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

  assign add_a = x_q[idx_q];
`ifdef WIDE_ADD_SEQUENCER_SUB_EN
  // Two's-complement subtract: x + ~y + 1, the +1 coming from the seeded carry.
  assign add_b = sub_q ? ~y_q[idx_q] : y_q[idx_q];
`else
  assign add_b = y_q[idx_q];
`endif

  carry_lookahead_adder #(
    .WIDTH(WIDTH)
  ) u_adder (
    .a   (add_a),
    .b   (add_b),
    .cin (carry_q),
    .sum (add_sum),
    .cout(add_cout)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef WIDE_ADD_SEQUENCER_SUB_EN
    sub_d   = sub_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          x_d   = x;
          y_d   = y;
          idx_d = '0;
`ifdef WIDE_ADD_SEQUENCER_SUB_EN
          sub_d   = sub;
          carry_d = sub ? 1'b1 : carry_in;
`else
          carry_d = carry_in;
`endif
          state_d = ADD;
        end
      end
      ADD: begin
        z_d[idx_q] = add_sum;
        carry_d    = add_cout;
        if (idx_q == LAST_IDX) begin
          cout_d  = add_cout;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef WIDE_ADD_SEQUENCER_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef WIDE_ADD_SEQUENCER_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  assign busy      = (state_q == ADD);
  assign done      = (state_q == DONE);
  assign z         = z_q;
  assign carry_out = cout_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed bench for wide_add_sequencer (WIDTH=8, CHUNKS=4); subtract vectors
// are included when WIDE_ADD_SEQUENCER_SUB_EN is defined.
module tb_wide_add_sequencer;

  localparam int WIDTH  = 8;
  localparam int CHUNKS = 4;
  localparam int N      = WIDTH * CHUNKS;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic         carry_in;
  logic [N-1:0] x;
  logic [N-1:0] y;
`ifdef WIDE_ADD_SEQUENCER_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [N-1:0] z;
  logic         carry_out;

  int checks = 0;
  int errors = 0;

  wide_add_sequencer #(
    .WIDTH (WIDTH),
    .CHUNKS(CHUNKS)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .carry_in (carry_in),
    .x        (x),
    .y        (y),
`ifdef WIDE_ADD_SEQUENCER_SUB_EN
    .sub      (sub),
`endif
    .busy     (busy),
    .done     (done),
    .z        (z),
    .carry_out(carry_out)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".busy"}, 64'(busy), 64'd0);
    check({tag, ".done"}, 64'(done), 64'd0);
  endtask

  // Called at a negedge; returns at the negedge after the done cycle.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic ci,
                        input logic s, input logic [N-1:0] ez, input logic ec,
                        input string tag);
    x        = a;
    y        = b;
    carry_in = ci;
`ifdef WIDE_ADD_SEQUENCER_SUB_EN
    sub      = s;
`else
    if (s) $display("note: %s needs subtract support", tag);
`endif
    start    = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    for (int k = 0; k < CHUNKS; k++) begin
      check({tag, ".busy_cyc"}, 64'(busy), 64'd1);
      check({tag, ".done_early"}, 64'(done), 64'd0);
      @(negedge clock);
    end
    check({tag, ".done"}, 64'(done), 64'd1);
    check({tag, ".busy_in_done"}, 64'(busy), 64'd0);
    check({tag, ".z"}, 64'(z), 64'(ez));
    check({tag, ".carry_out"}, 64'(carry_out), 64'(ec));
    @(negedge clock);
    check_idle({tag, ".after"});
    check({tag, ".z_held"}, 64'(z), 64'(ez));
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    carry_in = 1'b0;
    x        = '0;
    y        = '0;
`ifdef WIDE_ADD_SEQUENCER_SUB_EN
    sub      = 1'b0;
`endif
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_idle("reset");
    check("reset.z", 64'(z), 64'd0);
    check("reset.carry_out", 64'(carry_out), 64'd0);
    reset = 1'b0;
    x     = 32'hDEADBEEF;
    y     = 32'h01234567;
    repeat (10) @(negedge clock);
    check_idle("idle10");
    check("idle10.z", 64'(z), 64'd0);
    check("idle10.carry_out", 64'(carry_out), 64'd0);

    run_op(32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, "basic");
    run_op(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, "ripple");
    run_op(32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, "msb_carry");
    run_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, "chunk_carry");
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, "all_ones");

    // Starts during ADD and DONE must be ignored; operand changes have no effect.
    x = 32'h000000FF; y = 32'h00000001; carry_in = 1'b0; start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    x = 32'hAAAAAAAA; y = 32'h55555555; carry_in = 1'b1; start = 1'b1;
    check("ign.busy_add", 64'(busy), 64'd1);
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    check("ign.busy_last", 64'(busy), 64'd1);
    @(negedge clock);
    check("ign.done", 64'(done), 64'd1);
    check("ign.z", 64'(z), 64'h100);
    check("ign.carry_out", 64'(carry_out), 64'd0);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check_idle("ign.after_done");
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      check_idle("ign.no_second");
    end
    check("ign.z_held", 64'(z), 64'h100);

    // Put a non-zero result in place, then reset during the second ADD cycle.
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, "pre_rst");
    x = 32'h0F0F0F0F; y = 32'h01010101; carry_in = 1'b0; start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    check("midrst.busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_idle("midrst");
    check("midrst.z", 64'(z), 64'd0);
    check("midrst.carry_out", 64'(carry_out), 64'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check_idle("midrst.quiet");
    end
    run_op(32'h00000001, 32'h00000001, 1'b0, 1'b0, 32'h00000002, 1'b0, "post_rst");

`ifdef WIDE_ADD_SEQUENCER_SUB_EN
    run_op(32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, "sub_borrow");
    run_op(32'h00000007, 32'h00000005, 1'b0, 1'b1, 32'h00000002, 1'b1, "sub_plain");
    run_op(32'h12345678, 32'h12345678, 1'b0, 1'b1, 32'h00000000, 1'b1, "sub_equal");
    run_op(32'h00000001, 32'h00000001, 1'b1, 1'b0, 32'h00000003, 1'b0, "add_after_sub");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wide_add_sequencer.md
Name: wide_add_sequencer

Overview:
Multi-cycle controller that adds two wide operands (CHUNKS*WIDTH bits) on a single WIDTH-bit carry_lookahead_adder instance.
- Processes one WIDTH-bit chunk per clock, LSB chunk first.
- Chains the carry between chunks through a carry register.
- Sits between operand registers/switch front-end and the result display path; start/busy/done handshake.

Parameters:
WIDTH, 8, chunk width = adder width (1..32)
CHUNKS, 4, number of chunks per operand (2..16); total operand width N = WIDTH*CHUNKS

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high; clears all state
start  input  1  request; sampled only in IDLE
carry_in  input  1  initial carry, captured with operands on accepted start
x  input  N  operand A, captured on accepted start
y  input  N  operand B, captured on accepted start
busy  output  1  high while chunks are being added
done  output  1  single-cycle pulse; z/carry_out valid
z  output  N  sum, registered, held until next accepted start
carry_out  output  1  final carry of the most significant chunk, registered, held

Behaviour:
- Interface: one clock `clock`; `reset` is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, z=0, carry_out=0, chunk index=0, carry register=0, operand registers=0.
- FSM states: IDLE, ADD, DONE.
- IDLE: start=1 at edge T captures x, y, carry_in into internal registers; index<=0; state->ADD. start=0 keeps IDLE.
- ADD: adder inputs are chunk[index] of the captured x and y, plus the carry register.
  - At each edge, z chunk[index] <= adder sum and carry register <= adder carry_out.
  - index < CHUNKS-1: index++.
  - index = CHUNKS-1: carry_out <= adder carry_out; state->DONE.
- DONE: done=1 for exactly this one cycle; state->IDLE unconditionally.
- Latency: start accepted at edge T; busy=1 for cycles T+1..T+CHUNKS; done=1 in cycle T+CHUNKS+1; next start accepted at edge T+CHUNKS+2 at earliest.
- busy and done are decoded from the state register (glitch-free, registered) and are never high together.
- start while in ADD or DONE is ignored, not queued. Inputs x/y/carry_in changing after capture have no effect.
- z chunks not yet written during ADD keep the previous result's values. z is only guaranteed coherent while done=1 and thereafter until the next accepted start.
- Arithmetic is unsigned modulo 2^N. carry_out is bit N of x+y+carry_in.
- Reset asserted in any state (including mid-ADD) returns to IDLE at that edge with all reset values; no done pulse.
- Chunk index register width is $clog2(CHUNKS). Values >= CHUNKS are unreachable.

Optional Feature:
Macro WIDE_ADD_SEQUENCER_SUB_EN.
- Defined: adds input `sub` (1 bit), captured with the operands. When sub=1:
  - every y chunk is bitwise inverted before the adder;
  - the initial carry is forced to 1 (carry_in ignored);
  - z = x - y mod 2^N, and carry_out=1 means no borrow (x >= y).
- Not defined: no `sub` port; add-only behaviour exactly as above.

Decomposition:
- Shared package wide_add_pkg holds:
  - the state enum (IDLE, ADD, DONE);
  - a function returning the index width from CHUNKS.
- Single sub-module: the existing carry_lookahead_adder #(WIDTH), instantiated once and unmodified.
- Chunk mux, operand/result registers and FSM live in this module.

Test Plan:
- Reset/idle: reset=1 for 2 cycles, then idle -> busy=0, done=0, z=0, carry_out=0; start=0 for 10 cycles keeps outputs unchanged.
- Basic add (WIDTH=8, CHUNKS=4): x=0x12345678, y=0x11111111, carry_in=0, start pulse -> busy high 4 cycles, done in cycle 5, z=0x23456789, carry_out=0.
- Full carry ripple: x=0xFFFFFFFF, y=0x00000000, carry_in=1 -> z=0x00000000, carry_out=1. Also x=0xFFFFFFFF, y=0xFFFFFFFF, carry_in=1 -> z=0xFFFFFFFF, carry_out=1.
- Start while busy/done: second start with different operands during ADD and during the DONE cycle -> ignored; first result reported once; no second done pulse.
- Reset mid-operation: assert reset in 2nd ADD cycle -> next cycle state IDLE, z=0, busy=0, no done. A fresh start then computes 0x00000001+0x00000001 = 0x00000002.
- SUB_EN build: x=0x00000005, y=0x00000007, sub=1 -> z=0xFFFFFFFE, carry_out=0. x=7, y=5 -> z=0x00000002, carry_out=1.
